// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - parallel-to-serial shifter with a one-word hold buffer
// Words are taken on a valid/ready handshake and sent one bit per enabled clock.
module param_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_Data,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic                  serial_enable,
   input  logic                  serial_abort,
   output logic                  serial_data,
   output logic                  serial_done,
   output logic                  busy
);
   localparam int            CW   = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  hold_full;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         bit_idx;
   logic                  next_bit;
   logic                  accept;
   logic                  last_bit;
   logic                  shifter_free;

   assign data_ready   = ~hold_full;
   assign busy         = (state_q == LOADED);
   assign accept       = data_valid & ~hold_full;
   assign last_bit     = (state_q == LOADED) & serial_enable & (cnt == LAST);
   // A word offered while the final bit leaves goes straight into the shifter.
   assign shifter_free = (state_q == EMPTY) | last_bit;
   assign bit_idx      = MSB_FIRST ? (LAST - cnt) : cnt;

   always_comb begin
      next_bit = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (bit_idx == CW'(i)) next_bit = shift_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full   <= 1'b0;
         cnt         <= '0;
         serial_data <= 1'b0;
         serial_done <= 1'b0;
      end else if (serial_abort) begin
         state_q     <= EMPTY;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full   <= 1'b0;
         cnt         <= '0;
         serial_data <= 1'b0;
         serial_done <= 1'b0;
      end else begin
         serial_done <= 1'b0;
         if (state_q == LOADED && serial_enable) begin
            serial_data <= next_bit;
            cnt         <= cnt + 1'b1;
            if (cnt == LAST) begin
               serial_done <= 1'b1;
               cnt         <= '0;
               // Refill from the hold buffer so the next word follows with no gap.
               if (hold_full) begin
                  shift_q   <= hold_q;
                  hold_full <= 1'b0;
               end else begin
                  state_q <= EMPTY;
               end
            end
         end
         if (accept) begin
            if (shifter_free) begin
               shift_q <= P_Data;
               cnt     <= '0;
               state_q <= LOADED;
            end else begin
               hold_q    <= P_Data;
               hold_full <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_param_serializer.sv
// tb/tb_param_serializer.sv - bench for param_serializer (8 LSB, 8 MSB, 12 MSB instances)
module tb_param_serializer;
   logic        clk;
   logic        rst;
   logic [7:0]  p8;
   logic [11:0] p12;
   logic        data_valid;
   logic        serial_enable;
   logic        serial_abort;
   logic [2:0]  rdy;
   logic [2:0]  sd;
   logic [2:0]  dn;
   logic [2:0]  bz;

   int n_chk  = 0;
   int n_pass = 0;

   param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u0 (
      .clk(clk), .rst(rst), .P_Data(p8), .data_valid(data_valid), .data_ready(rdy[0]),
      .serial_enable(serial_enable), .serial_abort(serial_abort),
      .serial_data(sd[0]), .serial_done(dn[0]), .busy(bz[0]));
   param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u1 (
      .clk(clk), .rst(rst), .P_Data(p8), .data_valid(data_valid), .data_ready(rdy[1]),
      .serial_enable(serial_enable), .serial_abort(serial_abort),
      .serial_data(sd[1]), .serial_done(dn[1]), .busy(bz[1]));
   param_serializer #(.DATA_WIDTH(12), .MSB_FIRST(1'b1)) u2 (
      .clk(clk), .rst(rst), .P_Data(p12), .data_valid(data_valid), .data_ready(rdy[2]),
      .serial_enable(serial_enable), .serial_abort(serial_abort),
      .serial_data(sd[2]), .serial_done(dn[2]), .busy(bz[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Model: each instance holds the current word as a list of bits in send order
   // (entry 0 goes out next) plus a count of bits left, and an optional held word.
   int          mw[3] = '{8, 8, 12};
   bit          mm[3] = '{1'b0, 1'b1, 1'b1};
   logic [15:0] m_cur[3];
   logic [15:0] m_hold[3];
   int          m_n[3];
   bit          m_hv[3];
   logic        m_sd[3];
   logic        m_done[3];
   logic [15:0] m_w;
   bit          m_acc;

   function automatic logic [15:0] send_order(input logic [15:0] w, input int width, input bit msb);
      logic [15:0] s;
      s = '0;
      for (int k = 0; k < width; k++) s[k] = msb ? w[width-1-k] : w[k];
      return s;
   endfunction

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst || serial_abort) begin
            m_cur[i]  = '0;
            m_hold[i] = '0;
            m_n[i]    = 0;
            m_hv[i]   = 1'b0;
            m_sd[i]   = 1'b0;
            m_done[i] = 1'b0;
         end else begin
            m_w       = (i == 2) ? {4'b0, p12} : {8'b0, p8};
            m_acc     = data_valid && !m_hv[i];
            m_done[i] = 1'b0;
            if (m_n[i] > 0 && serial_enable) begin
               m_sd[i]  = m_cur[i][0];
               m_cur[i] = m_cur[i] >> 1;
               m_n[i]   = m_n[i] - 1;
               if (m_n[i] == 0) begin
                  m_done[i] = 1'b1;
                  if (m_hv[i]) begin
                     m_cur[i] = m_hold[i];
                     m_n[i]   = mw[i];
                     m_hv[i]  = 1'b0;
                  end
               end
            end
            if (m_acc) begin
               if (m_n[i] == 0) begin
                  m_cur[i] = send_order(m_w, mw[i], mm[i]);
                  m_n[i]   = mw[i];
               end else begin
                  m_hold[i] = send_order(m_w, mw[i], mm[i]);
                  m_hv[i]   = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d_serial_data", i), 32'(sd[i]),  32'(m_sd[i]));
         chk($sformatf("u%0d_serial_done", i), 32'(dn[i]),  32'(m_done[i]));
         chk($sformatf("u%0d_busy", i),        32'(bz[i]),  32'(m_n[i] != 0));
         chk($sformatf("u%0d_data_ready", i),  32'(rdy[i]), 32'(!m_hv[i]));
      end
   end

   task automatic step(input bit v, input logic [7:0] d8, input logic [11:0] d12,
                       input bit en, input bit ab);
      data_valid    = v;
      p8            = d8;
      p12           = d12;
      serial_enable = en;
      serial_abort  = ab;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] c0, c1, c2, d0, d1, d2;
   bit          en_pat[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};

   initial begin
      rst = 1'b1; p8 = '0; p12 = '0; data_valid = 1'b0; serial_enable = 1'b0; serial_abort = 1'b0;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_serial_data", 32'(sd), 32'h0);
      chk("reset_busy",        32'(bz), 32'h0);
      chk("reset_data_ready",  32'(rdy), 32'h7);
      rst = 1'b1;

      // 0xA5 on both 8-bit instances, 0x801 on the 12-bit one
      step(1, 8'hA5, 12'h801, 1, 0);
      c0 = '0; c1 = '0; c2 = '0; d0 = '0; d1 = '0; d2 = '0;
      for (int k = 0; k < 12; k++) begin
         step(0, 8'h00, 12'h000, 1, 0);
         c0[k] = sd[0]; c1[k] = sd[1]; c2[k] = sd[2];
         d0[k] = dn[0]; d1[k] = dn[1]; d2[k] = dn[2];
      end
      chk("lsb_a5_bits",  32'(c0[7:0]),  32'hA5);
      chk("lsb_a5_done",  32'(d0[11:0]), 32'h080);
      chk("msb_a5_bits",  32'(c1[7:0]),  32'hA5);
      chk("msb_a5_done",  32'(d1[11:0]), 32'h080);
      chk("w12_801_bits", 32'(c2[11:0]), 32'h801);
      chk("w12_801_done", 32'(d2[11:0]), 32'h800);

      // back-to-back words through the hold buffer
      step(1, 8'h3C, 12'hA5A, 1, 0);
      c0 = '0; d0 = '0;
      for (int k = 0; k < 16; k++) begin
         if (k == 0) step(1, 8'hC3, 12'h0F0, 1, 0);
         else        step(0, 8'h00, 12'h000, 1, 0);
         c0[k] = sd[0]; d0[k] = dn[0];
         if (k == 0) chk("b2b_ready_hold_full", 32'(rdy[0]), 32'h0);
         if (k == 7) chk("b2b_ready_after_8th", 32'(rdy[0]), 32'h1);
      end
      chk("b2b_bits", 32'(c0), 32'hC33C);
      chk("b2b_done", 32'(d0), 32'h8080);
      repeat (14) step(0, 8'h00, 12'h000, 1, 0);

      // pause for three cycles after bit 2
      step(1, 8'hF0, 12'hF0F, 0, 0);
      c0 = '0; d0 = '0;
      for (int k = 0; k < 11; k++) begin
         step(0, 8'h00, 12'h000, en_pat[k], 0);
         c0[k] = sd[0]; d0[k] = dn[0];
         if (k == 4) chk("pause_busy", 32'(bz[0]), 32'h1);
      end
      chk("pause_bits", 32'(c0[10:0]), 32'h780);
      chk("pause_done", 32'(d0[10:0]), 32'h400);
      repeat (14) step(0, 8'h00, 12'h000, 1, 0);

      // abort after four bits with the hold buffer full
      step(1, 8'h9B, 12'h9B9, 1, 0);
      step(1, 8'h66, 12'h666, 1, 0);
      repeat (3) step(0, 8'h00, 12'h000, 1, 0);
      chk("abort_pre_ready", 32'(rdy[0]), 32'h0);
      step(1, 8'hFF, 12'hFFF, 1, 1);
      chk("abort_busy",  32'(bz),  32'h0);
      chk("abort_ready", 32'(rdy), 32'h7);
      chk("abort_sd",    32'(sd),  32'h0);
      chk("abort_done",  32'(dn),  32'h0);
      d0 = '0;
      for (int k = 0; k < 2; k++) begin
         step(0, 8'h00, 12'h000, 1, 0);
         d0[k] = dn[0];
      end
      chk("abort_no_done", 32'(d0[1:0]), 32'h0);
      step(1, 8'h55, 12'h555, 1, 0);
      c0 = '0; d0 = '0;
      for (int k = 0; k < 8; k++) begin
         step(0, 8'h00, 12'h000, 1, 0);
         c0[k] = sd[0]; d0[k] = dn[0];
      end
      chk("post_abort_bits", 32'(c0[7:0]), 32'h55);
      chk("post_abort_done", 32'(d0[7:0]), 32'h80);
      repeat (6) step(0, 8'h00, 12'h000, 1, 0);

      // asynchronous reset in the middle of a word
      step(1, 8'hFF, 12'hFFF, 1, 0);
      repeat (3) step(0, 8'h00, 12'h000, 1, 0);
      chk("pre_reset_sd",   32'(sd[0]), 32'h1);
      chk("pre_reset_busy", 32'(bz[0]), 32'h1);
      rst = 1'b0;
      #1;
      chk("async_reset_sd",    32'(sd),  32'h0);
      chk("async_reset_done",  32'(dn),  32'h0);
      chk("async_reset_busy",  32'(bz),  32'h0);
      chk("async_reset_ready", 32'(rdy), 32'h7);
      step(0, 8'h00, 12'h000, 1, 0);
      rst = 1'b1;
      repeat (3) step(0, 8'h00, 12'h000, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
